// File: rtl/pix_gearbox_pkg.sv
// pix_gearbox_pkg: shared sizes and types for the 16-to-24 bit pixel gearbox
package pix_gearbox_pkg;
  localparam int BUF_BYTES = 6;
  localparam int BYTES_IN = 2;
  localparam int BYTES_OUT = 3;
  typedef logic [2:0] cnt_t;
endpackage

// File: rtl/pix_byte_buf.sv
// pix_byte_buf: 6-byte shift buffer, removes 3 oldest bytes and appends 2 new bytes per cycle
// Ports: clk, rst_n (async active-low), clr (sync clear), pop (drop 3 oldest bytes),
//        app (append din), base (write index after pop), din (low byte older), dout (3 oldest bytes)
module pix_byte_buf import pix_gearbox_pkg::*; #(parameter int DATA_WIDTH = 8) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clr,
  input  logic                              pop,
  input  logic                              app,
  input  logic [2:0]                        base,
  input  logic [BYTES_IN*DATA_WIDTH-1:0]    din,
  output logic [BYTES_OUT*DATA_WIDTH-1:0]   dout
);
  logic [DATA_WIDTH-1:0] b [BUF_BYTES];
  logic [DATA_WIDTH-1:0] nb [BUF_BYTES];
  always_comb begin
    for (int i = 0; i < BUF_BYTES; i++) nb[i] = b[i];
    if (pop)
      for (int i = 0; i < BUF_BYTES; i++)
        nb[i] = i < BUF_BYTES - BYTES_OUT ? b[(i + BYTES_OUT) % BUF_BYTES] : '0;
    if (app)
      for (int i = 0; i < BUF_BYTES; i++)
        for (int j = 0; j < BYTES_IN; j++)
          if (i == int'(base) + j) nb[i] = din[j*DATA_WIDTH +: DATA_WIDTH];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < BUF_BYTES; i++) b[i] <= '0;
    else if (clr) for (int i = 0; i < BUF_BYTES; i++) b[i] <= '0;
    else b <= nb;
  always_comb begin
    dout = '0;
    for (int i = 0; i < BYTES_OUT; i++) dout[i*DATA_WIDTH +: DATA_WIDTH] = b[i];
  end
endmodule

// File: rtl/pix_gearbox_16to24.sv
// pix_gearbox_16to24: converts a FIFO stream of 2-byte words into 3-byte pixels
// Ports: clk, rst_n (async active-low), rempty/rd_data/rd_data_valid/rinc (FIFO read side),
//        flush (sync clear), pix_data/pix_valid/pix_ready (pixel handshake), ovf_err (sticky),
//        pix_cnt (transfer counter, only with PIX_GEARBOX_STATS_EN defined)
module pix_gearbox_16to24 import pix_gearbox_pkg::*; #(parameter int DATA_WIDTH = 8) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rempty,
  input  logic [2*DATA_WIDTH-1:0] rd_data,
  input  logic                    rd_data_valid,
  output logic                    rinc,
  input  logic                    flush,
  output logic [3*DATA_WIDTH-1:0] pix_data,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic                    ovf_err
`ifdef PIX_GEARBOX_STATS_EN
  , output logic [15:0]           pix_cnt
`endif
);
  cnt_t cnt, base;
  logic pend, disc, run, pop, take, ovf, app;
  logic [3:0] need, room;
  always_comb begin
    pix_valid = cnt >= cnt_t'(BYTES_OUT);
    pop = pix_valid && pix_ready;
    base = pop ? cnt - cnt_t'(BYTES_OUT) : cnt;
    // free >= 2 rewritten as room >= need to stay unsigned
    need = 4'(cnt) + (pend ? 4'd2 : 4'd0) + 4'(BYTES_IN);
    room = 4'(BUF_BYTES) + (pop ? 4'(BYTES_OUT) : 4'd0);
    // run holds rinc low until the first clock edge after reset release
    rinc = run && !rempty && !flush && room >= need;
    take = rd_data_valid && !flush && !disc;
    ovf = take && base > cnt_t'(BUF_BYTES - BYTES_IN);
    app = take && !ovf;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= '0;
      pend <= 1'b0;
      disc <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      run <= 1'b1;
      cnt <= flush ? '0 : base + (app ? cnt_t'(BYTES_IN) : '0);
      pend <= rinc;
      // a word still in flight across a flush is dropped when it lands
      disc <= (disc || (flush && pend)) && !rd_data_valid;
      ovf_err <= ovf_err || ovf;
    end
`ifdef PIX_GEARBOX_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pix_cnt <= '0;
    else pix_cnt <= flush ? '0 : pix_cnt + 16'(pop);
`endif
  pix_byte_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .clr(flush),
    .pop(pop),
    .app(app),
    .base(base),
    .din(rd_data),
    .dout(pix_data)
  );
endmodule
